controle_exploracao: RTL
========================

# controle_exploracao

Sequencer for the frontier-search engine in the exploration datapath. Captures the robot pose from odometry and starts one search per pose. It freezes occupancy-grid writes while the search runs, supervises the search with a timeout/retry budget, and hands the chosen destination to the navigation block over a valid/ready handshake. It then waits for arrival before starting the next cycle, and reports when the map has no frontiers left.

## Interface
- tamanhoDistancia, 8, width of every coordinate
- TIMEOUT_CICLOS, 4096, cycles allowed per search attempt (≥2)
- MAX_TENTATIVAS, 3, search attempts before declaring failure (≥1)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- habilitar  in  1  exploration enable; low aborts to OCIOSO
- posicaoValida  in  1  one-cycle strobe qualifying posX/posY
- posX, posY  in  tamanhoDistancia  current robot cell
- buscaInicio  out  1  one-cycle start pulse to search engine
- buscaPosX, buscaPosY  out  tamanhoDistancia  latched pose, stable while malhaCongelada=1
- buscaFinalizada  in  1  one-cycle done strobe from engine
- buscaSemFronteira  in  1  qualified by buscaFinalizada: no frontier found
- buscaDestinoX, buscaDestinoY  in  tamanhoDistancia  result, qualified by buscaFinalizada
- malhaCongelada  out  1  grid writers must stall while high
- destinoValido  out  1  destination offer to navigation
- destinoPronto  in  1  navigation accepts
- destinoX, destinoY  out  tamanhoDistancia  destination, stable while destinoValido=1
- chegou  in  1  navigation arrival strobe
- explorando  out  1  high in any state except OCIOSO, COMPLETO, FALHA
- exploracaoCompleta  out  1  sticky; map has no frontier
- erroTimeout  out  1  sticky; retries exhausted

## Operation
- All outputs are registered. Reset value is 0 for every output, including coordinates. After reset the state is OCIOSO, the attempt counter is 0 and the timeout counter is 0.
- OCIOSO: if habilitar=1, go to AGUARDA_POSE and clear exploracaoCompleta and erroTimeout.
- AGUARDA_POSE: on posicaoValida, latch posX/posY into buscaPosX/buscaPosY and go to DISPARA.
- DISPARA: assert buscaInicio for this cycle only, set malhaCongelada=1, clear the timeout counter, then go to BUSCA.
- BUSCA: the timeout counter increments every cycle.
  - On buscaFinalizada with buscaSemFronteira=1: go to COMPLETO.
  - On buscaFinalizada with a frontier: latch buscaDestinoX/Y into destinoX/Y and go to ENTREGA.
  - If the counter reaches TIMEOUT_CICLOS-1 without buscaFinalizada: increment the attempt counter. Go to DISPARA if attempts < MAX_TENTATIVAS, otherwise go to FALHA.
  - If buscaFinalizada arrives in the same cycle as the timeout, buscaFinalizada wins.
- Leaving BUSCA by any path clears malhaCongelada.
- ENTREGA: destinoValido=1. When destinoValido and destinoPronto are both high at a rising edge, the transfer happens; drop destinoValido, clear the attempt counter, and go to NAVEGA.
- NAVEGA: on chegou, go to AGUARDA_POSE. A posicaoValida strobe received in NAVEGA is ignored.
- COMPLETO: set exploracaoCompleta=1 and hold. Go to OCIOSO when habilitar=0.
- FALHA: set erroTimeout=1 and hold. Go to OCIOSO when habilitar=0.
- habilitar=0 in any state other than OCIOSO forces OCIOSO on the next edge. On that edge:
  - clear malhaCongelada, buscaInicio, destinoValido and the attempt counter;
  - keep exploracaoCompleta and erroTimeout until the next habilitar rising edge.
  - This is the only case in which destinoValido may drop without a transfer.
- Strobes arriving in the wrong state (buscaFinalizada outside BUSCA, chegou outside NAVEGA) are ignored.
- Counters saturate and never wrap. The timeout counter is $clog2(TIMEOUT_CICLOS) bits wide.

## Timing
- Pose to start: posicaoValida sampled at edge N gives buscaInicio high during cycle N+1 to N+2, with malhaCongelada rising at edge N+1.
- Result to offer: buscaFinalizada sampled at edge M gives destinoValido=1 and valid destinoX/Y from edge M+1.
- destinoPronto may be high before destinoValido rises. The transfer then completes at the first edge where destinoValido=1, so the minimum offer length is one cycle.
- Retry gap: timeout at edge T gives a new buscaInicio pulse in cycle T+1, because the path goes through DISPARA. malhaCongelada stays low for exactly that one cycle.
- An active-low reset asserted mid-search returns every output to 0 on the next edge. No further buscaInicio is issued until a new pose arrives.

## Test plan
- Nominal path: habilitar=1, pose (5,7), engine returns (9,7) after 20 cycles, destinoPronto tied high.
  - buscaInicio is a single pulse.
  - malhaCongelada is high for 21 cycles.
  - destinoX/Y=(9,7) with destinoValido high for 1 cycle.
  - After chegou, the block is back in AGUARDA_POSE.
- Backpressure: destinoPronto held low for 10 cycles. destinoValido and (9,7) stay stable for all 10 cycles, and the transfer happens on the first edge with destinoPronto high.
- Timeout and retry: TIMEOUT_CICLOS=8, MAX_TENTATIVAS=3, engine silent.
  - Exactly three buscaInicio pulses, 9 cycles apart.
  - erroTimeout=1 after the third timeout, and the state holds in FALHA.
  - A done strobe injected on the timeout cycle of attempt 2 is accepted instead.
- No frontier: buscaFinalizada with buscaSemFronteira=1 gives exploracaoCompleta=1, malhaCongelada=0 and no destinoValido.
- Abort and reset: habilitar drops during ENTREGA, and a separate test pulls reset low mid-BUSCA. In both, all outputs go to 0 on the next edge, except the sticky flags under abort.

Source files
------------

// File: rtl/controle_exploracao_if.sv
// Handshake bundle between the exploration sequencer, the frontier-search engine,
// the odometry source and the navigation block.
interface controle_exploracao_if #(
   parameter int tamanhoDistancia = 8
);
   logic                        habilitar;
   logic                        posicaoValida;
   logic [tamanhoDistancia-1:0] posX;
   logic [tamanhoDistancia-1:0] posY;
   logic                        buscaInicio;
   logic [tamanhoDistancia-1:0] buscaPosX;
   logic [tamanhoDistancia-1:0] buscaPosY;
   logic                        buscaFinalizada;
   logic                        buscaSemFronteira;
   logic [tamanhoDistancia-1:0] buscaDestinoX;
   logic [tamanhoDistancia-1:0] buscaDestinoY;
   logic                        malhaCongelada;
   logic                        destinoValido;
   logic                        destinoPronto;
   logic [tamanhoDistancia-1:0] destinoX;
   logic [tamanhoDistancia-1:0] destinoY;
   logic                        chegou;
   logic                        explorando;
   logic                        exploracaoCompleta;
   logic                        erroTimeout;

   modport master (
      input  habilitar, posicaoValida, posX, posY,
      input  buscaFinalizada, buscaSemFronteira, buscaDestinoX, buscaDestinoY,
      input  destinoPronto, chegou,
      output buscaInicio, buscaPosX, buscaPosY, malhaCongelada,
      output destinoValido, destinoX, destinoY,
      output explorando, exploracaoCompleta, erroTimeout
   );

   modport slave (
      output habilitar, posicaoValida, posX, posY,
      output buscaFinalizada, buscaSemFronteira, buscaDestinoX, buscaDestinoY,
      output destinoPronto, chegou,
      input  buscaInicio, buscaPosX, buscaPosY, malhaCongelada,
      input  destinoValido, destinoX, destinoY,
      input  explorando, exploracaoCompleta, erroTimeout
   );
endinterface

// File: rtl/controle_exploracao.sv
// Exploration sequencer: pose capture, supervised frontier search with retry budget,
// destination hand-off to navigation and arrival wait. All outputs are registered.
module controle_exploracao #(
   parameter int tamanhoDistancia = 8,
   parameter int TIMEOUT_CICLOS   = 4096,
   parameter int MAX_TENTATIVAS   = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   controle_exploracao_if.master bus
);
   localparam int TW = $clog2(TIMEOUT_CICLOS);
   localparam int AW = $clog2(MAX_TENTATIVAS + 1);
   localparam logic [TW-1:0] LIMITE_TIMEOUT    = TW'(TIMEOUT_CICLOS - 1);
   localparam logic [AW-1:0] LIMITE_TENTATIVAS = AW'(MAX_TENTATIVAS);

   typedef enum logic [2:0] {
      OCIOSO       = 3'd0,
      AGUARDA_POSE = 3'd1,
      DISPARA      = 3'd2,
      BUSCA        = 3'd3,
      ENTREGA      = 3'd4,
      NAVEGA       = 3'd5,
      COMPLETO     = 3'd6,
      FALHA        = 3'd7
   } estado_t;

   estado_t                     estado_r, estado_s;
   logic [TW-1:0]               contTimeout_r, contTimeout_s;
   logic [AW-1:0]               tentativas_r, tentativas_s, tentInc_s;
   logic                        buscaInicio_r, buscaInicio_s;
   logic [tamanhoDistancia-1:0] buscaPosX_r, buscaPosX_s;
   logic [tamanhoDistancia-1:0] buscaPosY_r, buscaPosY_s;
   logic                        malhaCongelada_r, malhaCongelada_s;
   logic                        destinoValido_r, destinoValido_s;
   logic [tamanhoDistancia-1:0] destinoX_r, destinoX_s;
   logic [tamanhoDistancia-1:0] destinoY_r, destinoY_s;
   logic                        explorando_r, explorando_s;
   logic                        exploracaoCompleta_r, exploracaoCompleta_s;
   logic                        erroTimeout_r, erroTimeout_s;

   function automatic logic [TW-1:0] incTimeout(input logic [TW-1:0] v);
      return (v == {TW{1'b1}}) ? v : v + TW'(1'b1);
   endfunction

   function automatic logic [AW-1:0] incTentativas(input logic [AW-1:0] v);
      return (v == {AW{1'b1}}) ? v : v + AW'(1'b1);
   endfunction

   // Next-state and next-output computation for the sequencer.
   always_comb begin
      estado_s             = estado_r;
      contTimeout_s        = contTimeout_r;
      tentativas_s         = tentativas_r;
      tentInc_s            = incTentativas(tentativas_r);
      buscaInicio_s        = 1'b0;
      buscaPosX_s          = buscaPosX_r;
      buscaPosY_s          = buscaPosY_r;
      malhaCongelada_s     = malhaCongelada_r;
      destinoValido_s      = destinoValido_r;
      destinoX_s           = destinoX_r;
      destinoY_s           = destinoY_r;
      exploracaoCompleta_s = exploracaoCompleta_r;
      erroTimeout_s        = erroTimeout_r;

      if (!bus.habilitar && (estado_r != OCIOSO)) begin
         // Abort: everything drops except the sticky result flags.
         estado_s         = OCIOSO;
         contTimeout_s    = {TW{1'b0}};
         tentativas_s     = {AW{1'b0}};
         malhaCongelada_s = 1'b0;
         destinoValido_s  = 1'b0;
         buscaPosX_s      = {tamanhoDistancia{1'b0}};
         buscaPosY_s      = {tamanhoDistancia{1'b0}};
         destinoX_s       = {tamanhoDistancia{1'b0}};
         destinoY_s       = {tamanhoDistancia{1'b0}};
      end else begin
         case (estado_r)
            OCIOSO: begin
               if (bus.habilitar) begin
                  estado_s             = AGUARDA_POSE;
                  exploracaoCompleta_s = 1'b0;
                  erroTimeout_s        = 1'b0;
               end else begin
                  estado_s = OCIOSO;
               end
            end
            AGUARDA_POSE: begin
               if (bus.posicaoValida) begin
                  buscaPosX_s = bus.posX;
                  buscaPosY_s = bus.posY;
                  estado_s    = DISPARA;
               end else begin
                  estado_s = AGUARDA_POSE;
               end
            end
            DISPARA: begin
               buscaInicio_s    = 1'b1;
               malhaCongelada_s = 1'b1;
               contTimeout_s    = {TW{1'b0}};
               estado_s         = BUSCA;
            end
            BUSCA: begin
               contTimeout_s = incTimeout(contTimeout_r);
               // A done strobe on the timeout cycle takes priority over the retry.
               if (bus.buscaFinalizada) begin
                  malhaCongelada_s = 1'b0;
                  if (bus.buscaSemFronteira) begin
                     estado_s = COMPLETO;
                  end else begin
                     destinoX_s = bus.buscaDestinoX;
                     destinoY_s = bus.buscaDestinoY;
                     estado_s   = ENTREGA;
                  end
               end else if (contTimeout_r == LIMITE_TIMEOUT) begin
                  malhaCongelada_s = 1'b0;
                  tentativas_s     = tentInc_s;
                  if (tentInc_s < LIMITE_TENTATIVAS) begin
                     estado_s = DISPARA;
                  end else begin
                     estado_s = FALHA;
                  end
               end else begin
                  estado_s = BUSCA;
               end
            end
            ENTREGA: begin
               if (!destinoValido_r) begin
                  destinoValido_s = 1'b1;
               end else if (bus.destinoPronto) begin
                  destinoValido_s = 1'b0;
                  tentativas_s    = {AW{1'b0}};
                  estado_s        = NAVEGA;
               end else begin
                  destinoValido_s = 1'b1;
               end
            end
            NAVEGA: begin
               if (bus.chegou) begin
                  estado_s = AGUARDA_POSE;
               end else begin
                  estado_s = NAVEGA;
               end
            end
            COMPLETO: begin
               exploracaoCompleta_s = 1'b1;
            end
            FALHA: begin
               erroTimeout_s = 1'b1;
            end
            default: begin
               estado_s = OCIOSO;
            end
         endcase
      end

      explorando_s = (estado_s != OCIOSO) && (estado_s != COMPLETO) && (estado_s != FALHA);
   end

   // State, counters and registered outputs with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_r             <= OCIOSO;
         contTimeout_r        <= {TW{1'b0}};
         tentativas_r         <= {AW{1'b0}};
         buscaInicio_r        <= 1'b0;
         buscaPosX_r          <= {tamanhoDistancia{1'b0}};
         buscaPosY_r          <= {tamanhoDistancia{1'b0}};
         malhaCongelada_r     <= 1'b0;
         destinoValido_r      <= 1'b0;
         destinoX_r           <= {tamanhoDistancia{1'b0}};
         destinoY_r           <= {tamanhoDistancia{1'b0}};
         explorando_r         <= 1'b0;
         exploracaoCompleta_r <= 1'b0;
         erroTimeout_r        <= 1'b0;
      end else begin
         estado_r             <= estado_s;
         contTimeout_r        <= contTimeout_s;
         tentativas_r         <= tentativas_s;
         buscaInicio_r        <= buscaInicio_s;
         buscaPosX_r          <= buscaPosX_s;
         buscaPosY_r          <= buscaPosY_s;
         malhaCongelada_r     <= malhaCongelada_s;
         destinoValido_r      <= destinoValido_s;
         destinoX_r           <= destinoX_s;
         destinoY_r           <= destinoY_s;
         explorando_r         <= explorando_s;
         exploracaoCompleta_r <= exploracaoCompleta_s;
         erroTimeout_r        <= erroTimeout_s;
      end
   end

   assign bus.buscaInicio        = buscaInicio_r;
   assign bus.buscaPosX          = buscaPosX_r;
   assign bus.buscaPosY          = buscaPosY_r;
   assign bus.malhaCongelada     = malhaCongelada_r;
   assign bus.destinoValido      = destinoValido_r;
   assign bus.destinoX           = destinoX_r;
   assign bus.destinoY           = destinoY_r;
   assign bus.explorando         = explorando_r;
   assign bus.exploracaoCompleta = exploracaoCompleta_r;
   assign bus.erroTimeout        = erroTimeout_r;
endmodule
